// File: rtl/scratchmem_master.sv
// scratchmem_master: bus master in front of the 128-bit scratch memory.
// Queues CPU load/store requests in a DEPTH-entry FIFO and issues them one
// at a time as classic single bus cycles (cti=000). Captures read data on
// ack, returns a tagged one-cycle response, drains trailing acks for DRAIN
// cycles after every bus cycle, and aborts cycles unacked for TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_valid_i / req_ready_o     request handshake (ready = FIFO not full)
//   req_we/sel/adr/dat/tid_i      request payload
//   cs_o, cyc_o, stb_o, cti_o     bus strobes (all equal), cycle type (000)
//   we/sel/adr/dat/tid_o          registered bus fields, stable while strobed
//   ack_i, dat_i                  memory acknowledge and read data
//   resp_valid/we/err/tid/dat_o   one-cycle response pulse and payload
//
// DEPTH must be a power of two in 2..16; DRAIN and TIMEOUT must be >= 1.
module scratchmem_master #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DRAIN   = 3,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_we_i,
    input  logic [15:0]  req_sel_i,
    input  logic [17:0]  req_adr_i,
    input  logic [127:0] req_dat_i,
    input  logic [7:0]   req_tid_i,

    output logic         cs_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic [2:0]   cti_o,
    output logic         we_o,
    output logic [15:0]  sel_o,
    output logic [17:0]  adr_o,
    output logic [127:0] dat_o,
    output logic [7:0]   tid_o,
    input  logic         ack_i,
    input  logic [127:0] dat_i,

    output logic         resp_valid_o,
    output logic         resp_we_o,
    output logic         resp_err_o,
    output logic [7:0]   resp_tid_o,
    output logic [127:0] resp_dat_o
);

    localparam int unsigned SEL_W = 16;
    localparam int unsigned ADR_W = 18;
    localparam int unsigned DAT_W = 128;
    localparam int unsigned TID_W = 8;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [TID_W-1:0] tid;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DRAIN
    } state_t;

    state_t         state;
    req_t           fifo_mem [DEPTH];
    req_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           bus_act;
    logic           resp_pend;
    logic [TW-1:0]  tmo_cnt;
    logic [DW-1:0]  drn_cnt;

    // Request handshake; ready ignores a pop happening in the same cycle.
    assign req_ready_o = (count != CW'(DEPTH));
    assign push        = req_valid_i & req_ready_o;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign head        = fifo_mem[rd_ptr];

    assign cs_o  = bus_act;
    assign cyc_o = bus_act;
    assign stb_o = bus_act;
    assign cti_o = 3'b000;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_we_i, req_sel_i, req_adr_i, req_dat_i, req_tid_i};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Bus sequencer: IDLE -> BUS (until ack or timeout) -> DRAIN -> IDLE.
    // Response fields are loaded at the BUS exit edge, valid pulses one edge later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            bus_act      <= 1'b0;
            we_o         <= 1'b0;
            sel_o        <= '0;
            adr_o        <= '0;
            dat_o        <= '0;
            tid_o        <= '0;
            tmo_cnt      <= '0;
            drn_cnt      <= '0;
            resp_pend    <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_we_o    <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_tid_o   <= '0;
            resp_dat_o   <= '0;
        end else begin
            resp_valid_o <= resp_pend;
            resp_pend    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        we_o    <= head.we;
                        sel_o   <= head.sel;
                        adr_o   <= head.adr;
                        dat_o   <= head.dat;
                        tid_o   <= head.tid;
                        bus_act <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (ack_i) begin
                        bus_act    <= 1'b0;
                        resp_pend  <= 1'b1;
                        resp_we_o  <= we_o;
                        resp_tid_o <= tid_o;
                        resp_err_o <= 1'b0;
                        resp_dat_o <= we_o ? '0 : dat_i;
                        drn_cnt    <= '0;
                        state      <= S_DRAIN;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        bus_act    <= 1'b0;
                        resp_pend  <= 1'b1;
                        resp_we_o  <= we_o;
                        resp_tid_o <= tid_o;
                        resp_err_o <= 1'b1;
                        resp_dat_o <= '0;
                        drn_cnt    <= '0;
                        state      <= S_DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DRAIN: begin
                    // Trailing acks from the memory land here and are ignored.
                    if (drn_cnt == DW'(DRAIN - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        drn_cnt <= drn_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratchmem_master.sv
// Self-checking bench for scratchmem_master: a transaction-level reference
// model (request queue plus timestamps for bus start, exit and drain end)
// is compared against the DUT on every falling edge, with directed scenarios
// pinning latencies and orderings to hand-computed values, then random traffic.
module tb_scratchmem_master;

    localparam int DEPTH   = 4;
    localparam int DRAIN   = 3;
    localparam int TIMEOUT = 32;

    typedef struct packed {
        logic         we;
        logic [15:0]  sel;
        logic [17:0]  adr;
        logic [127:0] dat;
        logic [7:0]   tid;
    } mreq_t;

    typedef struct {
        logic         we;
        logic         err;
        logic [7:0]   tid;
        logic [127:0] dat;
        int           edge_n;
    } rsp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic         req_we_i = 1'b0;
    logic [15:0]  req_sel_i = '0;
    logic [17:0]  req_adr_i = '0;
    logic [127:0] req_dat_i = '0;
    logic [7:0]   req_tid_i = '0;
    logic         cs_o, cyc_o, stb_o;
    logic [2:0]   cti_o;
    logic         we_o;
    logic [15:0]  sel_o;
    logic [17:0]  adr_o;
    logic [127:0] dat_o;
    logic [7:0]   tid_o;
    logic         ack_i = 1'b0;
    logic [127:0] dat_i = '0;
    logic         resp_valid_o, resp_we_o, resp_err_o;
    logic [7:0]   resp_tid_o;
    logic [127:0] resp_dat_o;

    scratchmem_master #(.DEPTH(DEPTH), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_sel_i(req_sel_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .req_tid_i(req_tid_i),
        .cs_o(cs_o), .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .tid_o(tid_o),
        .ack_i(ack_i), .dat_i(dat_i),
        .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o), .resp_err_o(resp_err_o),
        .resp_tid_o(resp_tid_o), .resp_dat_o(resp_dat_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state.
    int           ecount = 0;
    mreq_t        mq[$];
    mreq_t        m_cur;
    bit           m_busy = 0;
    int           m_s = 0;
    int           m_next = 0;
    bit           m_rp = 0;
    int           m_rdue = 0;
    logic         m_r_we, m_r_err;
    logic [7:0]   m_r_tid;
    logic [127:0] m_r_dat;
    bit           exp_rv = 0;
    logic         e_we, e_err;
    logic [7:0]   e_tid;
    logic [127:0] e_dat;
    int           m_pre;
    bit           m_acc;
    int           cov_pp = 0;

    // Observations of the DUT used by directed literal checks.
    rsp_t got[$];
    int   rise_q[$];
    bit   prev_cyc = 0;

    // Memory model controls.
    int           mem_d = 0;      // ack when strobe has been high this many cycles; 0 = never
    int           mem_hold = 0;   // extra trailing ack cycles after the real ack
    bit           mem_noise = 0;  // random acks while idle
    bit           mem_fix = 0;
    logic [127:0] fix_dat = '0;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, ecount);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: request queue and bus-cycle timestamps, stepped per edge.
    initial begin : model
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                mq.delete();
                m_busy = 0;
                m_rp   = 0;
                exp_rv = 0;
                m_next = 0;
            end else begin
                ecount++;
                exp_rv = 0;
                if (m_rp && m_rdue == ecount) begin
                    exp_rv = 1;
                    e_we = m_r_we; e_err = m_r_err; e_tid = m_r_tid; e_dat = m_r_dat;
                    m_rp = 0;
                end
                m_pre = mq.size();
                m_acc = req_valid_i && (m_pre != DEPTH);
                if (m_busy) begin
                    if (ack_i || (ecount - m_s == TIMEOUT)) begin
                        m_r_err = !ack_i;
                        m_r_dat = (ack_i && !m_cur.we) ? dat_i : '0;
                        m_r_we  = m_cur.we;
                        m_r_tid = m_cur.tid;
                        m_busy  = 0;
                        m_next  = ecount + DRAIN + 1;
                        m_rp    = 1;
                        m_rdue  = ecount + 1;
                    end
                end else if (m_pre != 0 && ecount >= m_next) begin
                    m_cur  = mq.pop_front();
                    m_busy = 1;
                    m_s    = ecount;
                    if (m_acc && m_pre == DEPTH - 1) cov_pp++;
                end
                if (m_acc) mq.push_back({req_we_i, req_sel_i, req_adr_i, req_dat_i, req_tid_i});
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin : compare
        forever begin
            @(negedge clk_i);
            chk("cyc_o", 128'(cyc_o), 128'(m_busy));
            chk("stb_o", 128'(stb_o), 128'(m_busy));
            chk("cs_o", 128'(cs_o), 128'(m_busy));
            chk("cti_o", 128'(cti_o), 128'(0));
            chk("req_ready_o", 128'(req_ready_o), 128'(mq.size() != DEPTH));
            chk("resp_valid_o", 128'(resp_valid_o), 128'(exp_rv));
            if (m_busy) begin
                chk("we_o", 128'(we_o), 128'(m_cur.we));
                chk("sel_o", 128'(sel_o), 128'(m_cur.sel));
                chk("adr_o", 128'(adr_o), 128'(m_cur.adr));
                chk("dat_o", dat_o, m_cur.dat);
                chk("tid_o", 128'(tid_o), 128'(m_cur.tid));
            end
            if (exp_rv) begin
                chk("resp_we_o", 128'(resp_we_o), 128'(e_we));
                chk("resp_err_o", 128'(resp_err_o), 128'(e_err));
                chk("resp_tid_o", 128'(resp_tid_o), 128'(e_tid));
                chk("resp_dat_o", resp_dat_o, e_dat);
            end
            if (resp_valid_o)
                got.push_back('{we: resp_we_o, err: resp_err_o, tid: resp_tid_o,
                                dat: resp_dat_o, edge_n: ecount});
            if (cyc_o && !prev_cyc) rise_q.push_back(ecount);
            prev_cyc = cyc_o;
        end
    end

    // Memory model: acks mem_d cycles into a strobe, optional trailing/noise acks.
    initial begin : memory
        int k;
        int hold;
        k = 0;
        hold = 0;
        forever begin
            @(posedge clk_i);
            #1;
            dat_i = mem_fix ? fix_dat : rnd128();
            if (rst_i) begin
                k = 0; hold = 0; ack_i = 1'b0;
            end else if (cyc_o) begin
                k++;
                if (mem_d != 0 && k >= mem_d) begin
                    ack_i = 1'b1;
                    hold  = mem_hold;
                end else begin
                    ack_i = 1'b0;
                end
            end else begin
                k = 0;
                if (hold > 0) begin
                    ack_i = 1'b1;
                    hold--;
                end else begin
                    ack_i = mem_noise && ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    task automatic push(input logic we, input logic [15:0] sel, input logic [17:0] adr,
                        input logic [127:0] dat, input logic [7:0] tid);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        req_valid_i = 1'b1;
        req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = dat; req_tid_i = tid;
        while (!ok && n < 300) begin
            ok = req_ready_o;
            tick();
            n++;
        end
        req_valid_i = 1'b0;
        chk("push_accepted", 128'(ok), 128'(1));
    endtask

    task automatic wait_rise(input int budget);
        int n;
        n = 0;
        while (!cyc_o && n < budget) begin tick(); n++; end
        chk("strobe_rise", 128'(cyc_o), 128'(1));
    endtask

    task automatic wait_resp(input int target, input int budget);
        int n;
        n = 0;
        while (got.size() < target && n < budget) begin tick(); n++; end
        chk("resp_arrived", 128'(got.size() >= target), 128'(1));
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((m_busy || mq.size() != 0 || m_rp || exp_rv || ecount < m_next) && n < budget) begin
            tick(); n++;
        end
        chk("quiesce", 128'(m_busy || mq.size() != 0), 128'(0));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r0, ri, s0, e0;
        logic [7:0] exp_tids [6];

        // Reset state.
        #12;
        chk("reset_cyc", 128'(cyc_o), 128'(0));
        chk("reset_resp_valid", 128'(resp_valid_o), 128'(0));
        chk("reset_ready", 128'(req_ready_o), 128'(1));
        tick();
        rst_i = 1'b0;
        repeat (2) tick();

        // Single read: ack 3 cycles into strobe, response 4 cycles after rise.
        mem_d = 3; mem_hold = 0; mem_fix = 1; fix_dat = {16{8'hA5}};
        r0 = got.size(); ri = rise_q.size();
        push(1'b0, 16'hFFFF, 18'h00040, '0, 8'h11);
        wait_resp(r0 + 1, 30);
        if (got.size() > r0 && rise_q.size() > ri) begin
            chk("rd_latency", 128'(got[r0].edge_n - rise_q[ri]), 128'(4));
            chk("rd_tid", 128'(got[r0].tid), 128'(8'h11));
            chk("rd_we", 128'(got[r0].we), 128'(0));
            chk("rd_err", 128'(got[r0].err), 128'(0));
            chk("rd_dat", got[r0].dat, {16{8'hA5}});
        end
        wait_quiet(50);

        // Write with trailing acks, followed by a read that must wait for drain.
        mem_d = 2; mem_hold = 3; mem_fix = 0;
        r0 = got.size(); ri = rise_q.size();
        push(1'b1, 16'h00FF, 18'h00100, rnd128(), 8'h22);
        push(1'b0, 16'hFFFF, 18'h00200, '0, 8'h23);
        wait_resp(r0 + 2, 60);
        if (got.size() > r0 + 1 && rise_q.size() > ri + 1) begin
            chk("wr_dat_zero", got[r0].dat, 128'(0));
            chk("wr_tid", 128'(got[r0].tid), 128'(8'h22));
            chk("wr_we", 128'(got[r0].we), 128'(1));
            chk("wr_next_tid", 128'(got[r0 + 1].tid), 128'(8'h23));
            chk("wr_next_rise_gap", 128'(rise_q[ri + 1] - rise_q[ri]), 128'(6));
        end
        wait_quiet(50);

        // Fill behind a stalled cycle, then timeout and FIFO-order completion.
        mem_d = 0; mem_hold = 0;
        r0 = got.size(); ri = rise_q.size();
        push(1'b0, 16'h000F, 18'h00300, '0, 8'hEE);
        wait_rise(10);
        for (int t = 0; t < 4; t++) push(1'b1, 16'h1234, 18'(t * 16), rnd128(), 8'(t));
        chk("ready_low_when_full", 128'(req_ready_o), 128'(0));
        push(1'b0, 16'hFFFF, 18'h00400, '0, 8'h04);
        mem_d = 2;
        wait_resp(r0 + 6, 400);
        if (got.size() > r0 + 5 && rise_q.size() > ri) begin
            chk("tmo_resp_timing", 128'(got[r0].edge_n - rise_q[ri]), 128'(33));
            chk("tmo_err", 128'(got[r0].err), 128'(1));
            chk("tmo_dat", got[r0].dat, 128'(0));
            chk("tmo_tid", 128'(got[r0].tid), 128'(8'hEE));
            for (int t = 0; t < 5; t++) chk("fill_order", 128'(got[r0 + 1 + t].tid), 128'(t));
        end
        wait_quiet(100);

        // Push exactly on the pop edge while three entries are queued.
        mem_d = 0;
        r0 = got.size();
        push(1'b0, 16'hFFFF, 18'h00500, '0, 8'h80);
        wait_rise(10);
        for (int t = 1; t < 4; t++) push(1'b1, 16'hF0F0, 18'(t), rnd128(), 8'(8'h80 + t));
        begin
            int n;
            n = 0;
            while (cyc_o && n < 60) begin tick(); n++; end
        end
        e0 = ecount;
        while (ecount < e0 + DRAIN) tick();
        req_valid_i = 1'b1; req_we_i = 1'b0; req_sel_i = 16'hFFFF;
        req_adr_i = 18'h00600; req_tid_i = 8'h84;
        tick();
        req_valid_i = 1'b0;
        chk("pp_ready_after", 128'(req_ready_o), 128'(1));
        chk("pp_cyc_after", 128'(cyc_o), 128'(1));
        mem_d = 1;
        wait_resp(r0 + 5, 200);
        exp_tids = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h00};
        if (got.size() > r0 + 4)
            for (int t = 0; t < 5; t++) chk("pp_order", 128'(got[r0 + t].tid), 128'(exp_tids[t]));
        wait_quiet(100);

        // Asynchronous reset in the middle of a bus cycle.
        mem_d = 0;
        push(1'b0, 16'hFFFF, 18'h00700, '0, 8'h55);
        push(1'b0, 16'hFFFF, 18'h00710, '0, 8'h56);
        push(1'b0, 16'hFFFF, 18'h00720, '0, 8'h57);
        wait_rise(10);
        repeat (3) tick();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_cyc_async", 128'(cyc_o), 128'(0));
        chk("rst_stb_async", 128'(stb_o), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
        chk("rst_ready", 128'(req_ready_o), 128'(1));
        repeat (2) tick();
        rst_i = 1'b0;
        r0 = got.size(); ri = rise_q.size();
        repeat (40) tick();
        chk("rst_no_resp", 128'(got.size()), 128'(r0));
        chk("rst_no_strobe", 128'(rise_q.size()), 128'(ri));
        mem_d = 3; mem_fix = 1; fix_dat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        push(1'b0, 16'hFFFF, 18'h00800, '0, 8'h66);
        wait_resp(r0 + 1, 30);
        if (got.size() > r0) begin
            chk("post_rst_tid", 128'(got[r0].tid), 128'(8'h66));
            chk("post_rst_err", 128'(got[r0].err), 128'(0));
            chk("post_rst_dat", got[r0].dat, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        end
        wait_quiet(50);

        // Random traffic against the model.
        mem_fix = 0; mem_noise = 1;
        for (int i = 0; i < 600; i++) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_we_i    = 1'($urandom_range(0, 1));
            req_sel_i   = 16'($urandom());
            req_adr_i   = 18'($urandom());
            req_dat_i   = rnd128();
            req_tid_i   = 8'($urandom());
            if (!cyc_o) begin
                mem_d    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
                mem_hold = int'($urandom_range(0, 3));
            end
            tick();
        end
        req_valid_i = 1'b0;
        mem_d = 1; mem_noise = 0;
        wait_quiet(2000);
        chk("pushpop_at_depth_minus_1_seen", 128'(cov_pp > 0), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
